button_selector: RTL

- Parametrised successor to the per-button debounce plus program-select logic in the labkit top level.
- N raw pushbutton inputs go through a 2-flop synchroniser and a per-channel debounce counter.
- Each channel then gets edge detection, and a registered priority selector drives the processor's program_selector input.
- Two select modes:
  - level mode: the selector is valid only while a button is held, which is current behaviour;
  - latch mode: the selector holds the last pressed button until it is cleared.

---
 rtl/button_pkg.sv | 18 +
 rtl/debounce_channel.sv | 72 +++++++
 rtl/button_selector.sv | 82 ++++++++
 3 files changed

// File: rtl/button_pkg.sv
// button_pkg: shared constants and helpers
// for the button debounce / selector block.
package button_pkg;

  localparam int SEL_MODE_LEVEL = 0;
  localparam int SEL_MODE_LATCH = 1;

  // Ceiling log2; clog2(1) is 0.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// debounce_channel: 2-flop synchroniser, stable-count
// debounce and rise/fall pulses for one button.
module debounce_channel
  import button_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clock,
  input  logic reset,
  input  logic raw,
  output logic level,
  output logic rise,
  output logic fall
);

  localparam int CW =
    (clog2(DEBOUNCE_CYCLES) < 1) ? 1 : clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] TERM = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_q;
  logic          sync2_q;
  logic          stable_q;
  logic          stable_d;
  logic          rise_q;
  logic          rise_d;
  logic          fall_q;
  logic          fall_d;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Count while the input disagrees; flip level at terminal count.
  always_comb begin
    cnt_d    = cnt_q;
    stable_d = stable_q;
    rise_d   = 1'b0;
    fall_d   = 1'b0;
    if (sync2_q == stable_q) begin
      cnt_d = '0;
    end else if (cnt_q == TERM) begin
      cnt_d    = '0;
      stable_d = sync2_q;
      rise_d   = sync2_q;
      fall_d   = ~sync2_q;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Synchroniser, counter, level and pulse registers.
  always_ff @(posedge clock) begin
    if (!reset) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      cnt_q    <= '0;
      stable_q <= 1'b0;
      rise_q   <= 1'b0;
      fall_q   <= 1'b0;
    end else begin
      sync1_q  <= raw;
      sync2_q  <= sync1_q;
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
    end
  end

  assign level = stable_q;
  assign rise  = rise_q;
  assign fall  = fall_q;

endmodule

// File: rtl/button_selector.sv
// button_selector: debounced buttons feeding a registered
// priority selector (level or latch mode).
module button_selector
  import button_pkg::*;
#(
  parameter int NUM_BTNS        = 5,
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int SEL_WIDTH       = 32,
  parameter int SEL_MODE        = SEL_MODE_LEVEL
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [NUM_BTNS-1:0]  btn_in,
  input  logic                 clear,
  output logic [NUM_BTNS-1:0]  btn_level,
  output logic [NUM_BTNS-1:0]  btn_rise,
  output logic [NUM_BTNS-1:0]  btn_fall,
  output logic [SEL_WIDTH-1:0] selector,
  output logic                 sel_change
);

  logic [SEL_WIDTH-1:0] sel_q;
  logic [SEL_WIDTH-1:0] sel_d;
  logic                 chg_q;
  logic                 sel_change_q;

  // Lowest set index plus one; zero when nothing is set.
  function automatic logic [SEL_WIDTH-1:0] low_idx(
    input logic [NUM_BTNS-1:0] v
  );
    logic [SEL_WIDTH-1:0] r;
    r = '0;
    for (int i = NUM_BTNS - 1; i >= 0; i--) begin
      if (v[i]) r = SEL_WIDTH'(i + 1);
    end
    return r;
  endfunction

  for (genvar i = 0; i < NUM_BTNS; i++) begin : g_ch
    debounce_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_ch (
      .clock(clock),
      .reset(reset),
      .raw  (btn_in[i]),
      .level(btn_level[i]),
      .rise (btn_rise[i]),
      .fall (btn_fall[i])
    );
  end

  // Next selector: follow held buttons, or latch on presses.
  always_comb begin
    sel_d = sel_q;
    if (SEL_MODE == SEL_MODE_LATCH) begin
      if (clear) begin
        sel_d = '0;
      end else if (|btn_rise) begin
        sel_d = low_idx(btn_rise);
      end
    end else begin
      sel_d = low_idx(btn_level);
    end
  end

  // Selector register; change flag is delayed one cycle.
  always_ff @(posedge clock) begin
    if (!reset) begin
      sel_q        <= '0;
      chg_q        <= 1'b0;
      sel_change_q <= 1'b0;
    end else begin
      sel_q        <= sel_d;
      chg_q        <= (sel_d != sel_q);
      sel_change_q <= chg_q;
    end
  end

  assign selector   = sel_q;
  assign sel_change = sel_change_q;

endmodule
